// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 8-bit CPU datapath: fetch/decode/exec/mem phases,
// ready/valid memory handshakes with wait-state timeouts, and datapath control fields.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned PC_STEP = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN_L,
  input  logic [15:0] IMEM_DATA,
  input  logic        IMEM_RDY,
  input  logic        DMEM_RDY,
  output logic        IMEM_REQ,
  output logic        DMEM_REQ,
  output logic        PC_INC,
  output logic [7:0]  PC,
  output logic [15:0] IR,
  output logic [2:0]  SA,
  output logic [2:0]  SB,
  output logic [2:0]  DR,
  output logic        LD,
  output logic        MW,
  output logic        MB,
  output logic        MD,
  output logic [2:0]  FS,
  output logic [5:0]  IMM,
  output logic [2:0]  STATE,
  output logic        ERR
);

  localparam int unsigned CW = 8;
  localparam int unsigned PW = 8;
  localparam int unsigned IW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PC_ADD   = PW'(PC_STEP);

  localparam logic [3:0] OP_LB   = 4'h2;
  localparam logic [3:0] OP_SB   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_ALU  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_ERROR  = 3'd7
  } state_e;

  state_e          state_q, state_d, boundary_c;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc_c;
  logic [PW-1:0]   pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            err_q, err_d;
  logic            fields_en_c;

  logic [3:0]      opcode_c;
  logic [2:0]      dec_sa_c, dec_sb_c, dec_dr_c, dec_fs_c;
  logic [5:0]      dec_imm_c;
  logic            dec_mb_c, wr_exec_c, is_lb_c, is_sb_c;

  assign opcode_c   = ir_q[15:12];
  assign cnt_inc_c  = cnt_q + CW'(1);
  assign boundary_c = EN_L ? S_IDLE : S_FETCH;

  // Instruction decode; unknown opcodes fall through as NOP with ALU-row fields
  always_comb begin
    dec_sa_c  = ir_q[11:9];
    dec_sb_c  = ir_q[8:6];
    dec_dr_c  = ir_q[5:3];
    dec_fs_c  = ir_q[2:0];
    dec_imm_c = '0;
    dec_mb_c  = 1'b0;
    wr_exec_c = 1'b0;
    is_lb_c   = 1'b0;
    is_sb_c   = 1'b0;
    case (opcode_c)
      OP_ALU: wr_exec_c = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dec_sb_c  = '0;
        dec_dr_c  = ir_q[8:6];
        dec_imm_c = ir_q[5:0];
        dec_mb_c  = 1'b1;
        wr_exec_c = 1'b1;
        dec_fs_c  = (opcode_c == OP_ANDI) ? 3'b101 :
                    (opcode_c == OP_ORI)  ? 3'b110 : 3'b000;
      end
      OP_LB: begin
        dec_sb_c  = '0;
        dec_dr_c  = ir_q[8:6];
        dec_imm_c = ir_q[5:0];
        dec_mb_c  = 1'b1;
        dec_fs_c  = 3'b000;
        is_lb_c   = 1'b1;
      end
      OP_SB: begin
        dec_dr_c  = '0;
        dec_imm_c = ir_q[5:0];
        dec_mb_c  = 1'b1;
        dec_fs_c  = 3'b000;
        is_sb_c   = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, handshake strobes and datapath controls
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ir_d        = ir_q;
    err_d       = err_q;
    IMEM_REQ    = 1'b0;
    DMEM_REQ    = 1'b0;
    PC_INC      = 1'b0;
    LD          = 1'b0;
    MW          = 1'b0;
    MD          = 1'b0;
    fields_en_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!EN_L) state_d = S_FETCH;
      end
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_RDY) begin
          ir_d    = IMEM_DATA;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNT_LAST) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_DECODE: begin
        fields_en_c = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        fields_en_c = 1'b1;
        if (is_lb_c || is_sb_c) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          PC_INC  = 1'b1;
          LD      = wr_exec_c;
          state_d = boundary_c;
        end
      end
      S_MEM: begin
        fields_en_c = 1'b1;
        DMEM_REQ    = 1'b1;
        MW          = is_sb_c;
        if (DMEM_RDY) begin
          PC_INC  = 1'b1;
          LD      = is_lb_c;
          MD      = is_lb_c;
          cnt_d   = '0;
          state_d = boundary_c;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNT_LAST) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_ERROR: err_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
    SA  = fields_en_c ? dec_sa_c  : '0;
    SB  = fields_en_c ? dec_sb_c  : '0;
    DR  = fields_en_c ? dec_dr_c  : '0;
    FS  = fields_en_c ? dec_fs_c  : '0;
    IMM = fields_en_c ? dec_imm_c : '0;
    MB  = fields_en_c & dec_mb_c;
  end

  assign pc_d = PC_INC ? (pc_q + PC_ADD) : pc_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign STATE = state_q;
  assign PC    = pc_q;
  assign IR    = ir_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table-driven instruction vectors retired through a
// scoreboard, plus hand-written timeout, EN_L and reset corner sequences.
module tb_multicycle_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned PC_STEP = 2;

  logic        CLK = 1'b0;
  logic        RESET, EN_L, IMEM_RDY, DMEM_RDY;
  logic [15:0] IMEM_DATA;
  logic        IMEM_REQ, DMEM_REQ, PC_INC, LD, MW, MB, MD, ERR;
  logic [7:0]  PC;
  logic [15:0] IR;
  logic [2:0]  SA, SB, DR, FS, STATE;
  logic [5:0]  IMM;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .PC_STEP(PC_STEP)) dut (
    .CLK(CLK), .RESET(RESET), .EN_L(EN_L), .IMEM_DATA(IMEM_DATA),
    .IMEM_RDY(IMEM_RDY), .DMEM_RDY(DMEM_RDY), .IMEM_REQ(IMEM_REQ),
    .DMEM_REQ(DMEM_REQ), .PC_INC(PC_INC), .PC(PC), .IR(IR), .SA(SA), .SB(SB),
    .DR(DR), .LD(LD), .MW(MW), .MB(MB), .MD(MD), .FS(FS), .IMM(IMM),
    .STATE(STATE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] instr;
    int          iwait;
    int          dwait;
    logic [2:0]  st, sa, sb, dr, fs;
    logic [5:0]  imm;
    logic        mb, md, ld, mw;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    vec_t       v;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_pc = 8'h00;
  vec_t       vecs[9];
  vec_t       alu_v, nop_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Retire monitor: every PC_INC pops one expected instruction
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (LD || MW || PC_INC) chk("strobe_state", 32'(STATE == 3'd3 || STATE == 3'd4), 32'd1);
        if (LD) chk("ld_needs_retire", 32'(PC_INC), 32'd1);
        if (PC_INC) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire: pc=%0h ir=%0h with nothing pending", PC, IR);
          end else begin
            e = sb_q.pop_front();
            chk("retire_pc",    32'(PC),    32'(e.pc));
            chk("retire_ir",    32'(IR),    32'(e.v.instr));
            chk("retire_state", 32'(STATE), 32'(e.v.st));
            chk("retire_sa",    32'(SA),    32'(e.v.sa));
            chk("retire_sb",    32'(SB),    32'(e.v.sb));
            chk("retire_dr",    32'(DR),    32'(e.v.dr));
            chk("retire_fs",    32'(FS),    32'(e.v.fs));
            chk("retire_imm",   32'(IMM),   32'(e.v.imm));
            chk("retire_mb",    32'(MB),    32'(e.v.mb));
            chk("retire_md",    32'(MD),    32'(e.v.md));
            chk("retire_ld",    32'(LD),    32'(e.v.ld));
            chk("retire_mw",    32'(MW),    32'(e.v.mw));
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; EN_L = 1'b1; IMEM_RDY = 1'b0; DMEM_RDY = 1'b0; IMEM_DATA = 16'h0;
    step();
    step();
    chk("reset_state",   32'(STATE), 32'd0);
    chk("reset_pc",      32'(PC),    32'd0);
    chk("reset_ir",      32'(IR),    32'd0);
    chk("reset_err",     32'(ERR),   32'd0);
    chk("reset_strobes", 32'({IMEM_REQ, DMEM_REQ, PC_INC, LD, MW, MB, MD}), 32'd0);
    chk("reset_fields",  32'({SA, SB, DR, FS, IMM}), 32'd0);
    chk("sb_drained",    32'(sb_q.size()), 32'd0);
    sb_q.delete();
    RESET  = 1'b0;
    exp_pc = 8'h00;
  endtask

  // Serve one fetch; cyc = cycles spent in FETCH, ok = reached DECODE
  task automatic fetch_phase(input logic [15:0] w, input int iwait, output int cyc, output logic ok);
    int n;
    n = 0;
    EN_L = 1'b0;
    DMEM_RDY = 1'b1;
    while (STATE != 3'd1 && n < 20) begin step(); n++; end
    chk("reach_fetch", 32'(STATE), 32'd1);
    IMEM_DATA = w;
    IMEM_RDY  = (iwait == 0);
    cyc = 0;
    do begin
      step();
      cyc++;
      IMEM_RDY = (cyc >= iwait);
    end while (STATE == 3'd1 && cyc < 40);
    IMEM_RDY = 1'b0;
    ok = (STATE == 3'd2);
  endtask

  task automatic do_instr(input vec_t v, input logic en_after);
    int   cyc, n;
    logic ok;
    sb_q.push_back('{exp_pc, v});
    exp_pc = exp_pc + 8'(PC_STEP);
    fetch_phase(v.instr, v.iwait, cyc, ok);
    chk("fetch_ok",     32'(ok),  32'd1);
    chk("fetch_cycles", 32'(cyc), 32'(v.iwait + 1));
    chk("decode_ir",    32'(IR),  32'(v.instr));
    EN_L = en_after;
    n = 0;
    if (v.st == 3'd4) begin
      while (STATE != 3'd4 && n < 5) begin step(); n++; end
      DMEM_RDY = (v.dwait == 0);
      cyc = 0;
      do begin
        step();
        cyc++;
        DMEM_RDY = (cyc >= v.dwait);
      end while (STATE == 3'd4 && cyc < 40);
      DMEM_RDY = 1'b0;
      chk("mem_cycles", 32'(cyc), 32'(v.dwait + 1));
    end else begin
      while ((STATE == 3'd2 || STATE == 3'd3) && n < 5) begin step(); n++; end
    end
    chk("pc_after",    32'(PC),    32'(exp_pc));
    chk("state_after", 32'(STATE), en_after ? 32'd0 : 32'd1);
  endtask

  initial begin
    int   cyc, mw_cnt, n;
    logic ok;
    logic [7:0] pc_hold;
    RESET = 1'b1;
    //              instr     iw dw st    sa    sb    dr    fs    imm     mb    md    ld    mw
    vecs[0] = '{16'h5045, 0, 0, 3'd3, 3'd0, 3'd0, 3'd1, 3'd0, 6'h05, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'hFE3F, 2, 0, 3'd3, 3'd7, 3'd0, 3'd7, 3'd7, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h6A7F, 6, 0, 3'd3, 3'd5, 3'd0, 3'd1, 3'd5, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h7E40, 1, 0, 3'd3, 3'd7, 3'd0, 3'd1, 3'd6, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h2283, 0, 3, 3'd4, 3'd1, 3'd0, 3'd2, 3'd0, 6'h03, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h4281, 0, 0, 3'd4, 3'd1, 3'd2, 3'd0, 3'd0, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 0, 0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h9ABC, 0, 0, 3'd3, 3'd5, 3'd2, 3'd7, 3'd4, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'h2283, 3, 6, 3'd4, 3'd1, 3'd0, 3'd2, 3'd0, 6'h03, 1'b1, 1'b1, 1'b1, 1'b0};
    alu_v   = '{16'hF2C8, 0, 0, 3'd3, 3'd1, 3'd3, 3'd1, 3'd0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    nop_v   = vecs[6];

    fork monitor(); join_none

    do_reset();
    foreach (vecs[i]) do_instr(vecs[i], 1'b0);

    // EN_L raised mid-instruction: ALU op completes, then IDLE, then resumes
    do_instr(alu_v, 1'b1);
    pc_hold = PC;
    step(); step(); step();
    chk("idle_hold_state", 32'(STATE), 32'd0);
    chk("idle_hold_pc",    32'(PC),    32'(pc_hold));
    do_instr(nop_v, 1'b0);

    // Store never acknowledged: MW for TIMEOUT-1 cycles, then sticky ERROR
    do_reset();
    fetch_phase(16'h4281, 0, cyc, ok);
    n = 0;
    while (STATE != 3'd4 && n < 5) begin step(); n++; end
    DMEM_RDY = 1'b0;
    mw_cnt = 0;
    cyc = 0;
    while (STATE == 3'd4 && cyc < 40) begin
      if (MW) mw_cnt++;
      step();
      cyc++;
    end
    chk("sb_to_mw_cycles", 32'(mw_cnt),   32'(TIMEOUT - 1));
    chk("sb_to_state",     32'(STATE),    32'd7);
    chk("sb_to_err",       32'(ERR),      32'd1);
    chk("sb_to_mw",        32'(MW),       32'd0);
    chk("sb_to_dmem_req",  32'(DMEM_REQ), 32'd0);
    DMEM_RDY = 1'b1;
    IMEM_RDY = 1'b1;
    step(); step(); step();
    chk("err_sticky_state", 32'(STATE), 32'd7);
    chk("err_sticky_flag",  32'(ERR),   32'd1);
    chk("err_frozen_pc",    32'(PC),    32'd0);
    chk("err_frozen_ir",    32'(IR),    32'h4281);

    // Instruction fetch never ready: ERROR after TIMEOUT-1 cycles
    do_reset();
    fetch_phase(16'h5045, 1000, cyc, ok);
    chk("fetch_to_ok",     32'(ok),       32'd0);
    chk("fetch_to_cycles", 32'(cyc),      32'(TIMEOUT - 1));
    chk("fetch_to_state",  32'(STATE),    32'd7);
    chk("fetch_to_err",    32'(ERR),      32'd1);
    chk("fetch_to_req",    32'(IMEM_REQ), 32'd0);
    chk("fetch_to_ir",     32'(IR),       32'd0);

    // Reset in the middle of a store aborts at once
    do_reset();
    do_instr(nop_v, 1'b0);
    fetch_phase(16'h4281, 0, cyc, ok);
    n = 0;
    while (STATE != 3'd4 && n < 5) begin step(); n++; end
    DMEM_RDY = 1'b0;
    step();
    chk("mid_mem_mw", 32'(MW), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("abort_mw",     32'(MW),     32'd0);
    chk("abort_pc_inc", 32'(PC_INC), 32'd0);
    chk("abort_state",  32'(STATE),  32'd0);
    chk("abort_pc",     32'(PC),     32'd0);
    sb_q.delete();
    do_reset();

    // 128 NOPs: PC walks through 0xFE and wraps to 0x00
    for (int i = 0; i < 128; i++) do_instr(nop_v, 1'b0);
    chk("wrap_pc", 32'(PC), 32'd0);

    EN_L = 1'b1;
    step(); step(); step(); step();
    chk("final_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the 8-bit CPU datapath (register file, ALU, B/D muxes, sign extender). It splits each instruction into fetch, decode, execute and memory phases. It performs ready/valid handshakes with instruction and data memory, using wait-state timeouts. It drives the datapath control fields that the single-cycle decoder drives today, plus a PC-advance strobe.

Parameters:
TIMEOUT, 8, max cycles to wait for IMEM_RDY/DMEM_RDY before entering ERROR (legal 2..255)
PC_STEP, 2, byte increment applied to PC on PC_INC

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous active-high reset
EN_L  input  1  active-low run enable, sampled only at instruction boundaries
IMEM_DATA  input  16  instruction word from instruction memory
IMEM_RDY  input  1  instruction memory ready; IMEM_DATA valid when high
DMEM_RDY  input  1  data memory ready; load data valid / store accepted when high
IMEM_REQ  output  1  instruction fetch request
DMEM_REQ  output  1  data memory access request
PC_INC  output  1  one-cycle strobe; datapath PC <= PC + PC_STEP at this edge
PC  output  8  program counter, owned by this block
IR  output  16  latched instruction register
SA  output  3  register file read port A select
SB  output  3  register file read port B select
DR  output  3  register file write select
LD  output  1  register file write enable (one cycle)
MW  output  1  data memory write enable
MB  output  1  B-input mux select (1 = sign-extended IMM)
MD  output  1  writeback mux select (1 = Din)
FS  output  3  ALU function select
IMM  output  6  immediate field to sign extender
STATE  output  3  encoded state: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 ERROR=7
ERR  output  1  sticky timeout flag

Behaviour:
- RESET asserted (async): STATE=IDLE, PC=0, IR=0, wait counter=0, ERR=0. All strobes (IMEM_REQ, DMEM_REQ, PC_INC, LD, MW, MB, MD) are 0, and SA/SB/DR/FS/IMM are 0.
- IDLE: at the edge, EN_L=0 -> FETCH; otherwise stay.
- FETCH: IMEM_REQ=1.
  - IMEM_RDY=1 at the edge: IR<=IMEM_DATA, counter<=0, -> DECODE.
  - Otherwise counter increments. When counter reaches TIMEOUT-1 with RDY still low -> ERROR.
- DECODE: exactly one cycle. Control fields are driven from IR and held through EXEC/MEM. -> EXEC.
- Decode table (opcode = IR[15:12]):
  - 1111 ALU: SA=IR[11:9], SB=IR[8:6], DR=IR[5:3], FS=IR[2:0], MB=0, MD=0.
  - 0101 ADDI: FS=000. 0110 ANDI: FS=101. 0111 ORI: FS=110. For all three: SA=IR[11:9], DR=IR[8:6], IMM=IR[5:0], MB=1, MD=0.
  - 0010 LB: SA=IR[11:9], DR=IR[8:6], IMM=IR[5:0], MB=1, FS=000, MD=1.
  - 0100 SB: SA=IR[11:9], SB=IR[8:6], IMM=IR[5:0], MB=1, FS=000.
  - 0000 and all other opcodes: NOP, no writes, fields as in the ALU row.
- EXEC:
  - ALU/ADDI/ANDI/ORI: LD=1 and PC_INC=1 for this single cycle.
  - NOP: PC_INC=1 only.
  - In all of the above cases, the next state is FETCH if EN_L=0, else IDLE.
  - LB/SB: no strobes, -> MEM, counter<=0.
- MEM: DMEM_REQ=1. For SB, MW=1 is held for every MEM cycle.
  - DMEM_RDY=1 in the cycle: PC_INC=1. LB additionally gets LD=1, MD=1. Next state is FETCH/IDLE per EN_L.
  - Timeout rule is the same as FETCH -> ERROR.
- ERROR: ERR=1, all strobes 0, PC and IR frozen. Exit only via RESET.
- PC: PC <= PC + PC_STEP modulo 256 on any edge where PC_INC=1. Wraps 0xFE -> 0x00 with no flag.
- LD, PC_INC and MW are never asserted outside EXEC/MEM.
- LD is at most one cycle per instruction.
- Strobes are combinational from state, IR and the RDY inputs.
- RDY inputs are ignored when the corresponding REQ is 0.
- EN_L deassertion mid-instruction does not abort: the instruction completes, then the block goes to IDLE.
- RESET mid-MEM aborts immediately: MW drops asynchronously and no PC_INC occurs.

Test Plan:
- Reset, EN_L=0, IMEM_RDY=1, IMEM_DATA=0x5045 (ADDI R0->R1, IMM=5) -> states 1,2,3 then FETCH. LD=1 for one cycle in EXEC with DR=1, MB=1, FS=000, IMM=5. PC 0->2.
- LB 0x2283 with DMEM_RDY low 3 cycles then high (TIMEOUT=8) -> DMEM_REQ high 4 cycles. LD=1, MD=1, DR=2 only in the final cycle. PC +2 once.
- SB 0x4281, DMEM_RDY never high, TIMEOUT=8 -> MW high for 7 MEM cycles, then STATE=7, ERR=1, MW=0. PC unchanged until RESET.
- Fetch with IMEM_RDY low for TIMEOUT-1 cycles -> ERROR. Variant with RDY rising on cycle TIMEOUT-2 -> normal DECODE.
- EN_L raised during EXEC of an ALU op (0xF2C8) -> LD still pulses, PC advances, STATE=IDLE. Lowering EN_L resumes FETCH at the new PC.
- Run 128 NOPs (0x0000) from PC=0 -> PC wraps 0xFE->0x00. LD and MW are never asserted.
